// File: rtl/conv_pkg.sv
// Shared types, constants and helpers for the punctured convolutional encoder.
package conv_pkg;

  // Galileo rate-1/2, K=7 code: coded bit 0 uses 171, coded bit 1 uses 133 and is inverted.
  localparam logic [6:0] G_171   = 7'o171;
  localparam logic [6:0] G_133   = 7'o133;
  localparam logic [1:0] GAL_INV = 2'b10;

  // Largest supported constraint length and coded bits per input bit.
  localparam int MAX_K = 9;
  localparam int MAX_R = 4;

  typedef enum logic {
    ST_DATA = 1'b0,
    ST_TAIL = 1'b1
  } conv_state_t;

  // Parity of the register taps selected by a generator polynomial.
  function automatic logic conv_parity(input logic [MAX_K-1:0] poly,
                                       input logic [MAX_K-1:0] sr);
    return ^(poly & sr);
  endfunction

  // Number of coded bits a keep mask lets through.
  function automatic int unsigned punct_kept(input logic [MAX_R-1:0] mask);
    int unsigned n;
    n = 0;
    for (int i = 0; i < MAX_R; i++) begin
      n = n + 32'(mask[i]);
    end
    return n;
  endfunction

endpackage

// File: rtl/conv_serializer.sv
// Holds one coded symbol and shifts out its kept bits, lowest index first.
module conv_serializer
  import conv_pkg::*;
#(
  parameter int R  = 2,
  parameter int RW = $clog2(R + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load_i,
  input  logic [R-1:0]  bits_i,
  input  logic [R-1:0]  keep_i,
  input  logic          last_i,
  output logic          out_valid_o,
  input  logic          out_ready_i,
  output logic          out_bit_o,
  output logic          out_last_o,
  output logic          empty_o,
  output logic [RW-1:0] remaining_o
);

  logic [R-1:0]     bits_q, bits_d;
  logic [R-1:0]     keep_q, keep_d;
  logic             last_q, last_d;
  logic [R-1:0]     lowest;
  logic [MAX_R-1:0] keep_ext;

  // Pick the lowest pending kept bit, retire it on a transfer, accept a new symbol on load.
  always_comb begin
    lowest      = keep_q & (~keep_q + R'(1));
    keep_ext    = '0;
    keep_ext[R-1:0] = keep_q;
    remaining_o = RW'(punct_kept(keep_ext));
    empty_o     = (keep_q == '0);
    out_valid_o = !empty_o;
    out_bit_o   = |(bits_q & lowest);
    out_last_o  = last_q & (remaining_o == RW'(1));

    bits_d = bits_q;
    keep_d = keep_q;
    last_d = last_q;
    if (out_valid_o && out_ready_i) begin
      keep_d = keep_q & ~lowest;
    end
    // The top only loads when the current symbol is gone or leaving this cycle.
    if (load_i) begin
      bits_d = bits_i;
      keep_d = keep_i;
      last_d = last_i;
    end
  end

  // Symbol holding registers; an empty keep mask means nothing pending.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bits_q <= '0;
      keep_q <= '0;
      last_q <= 1'b0;
    end else begin
      bits_q <= bits_d;
      keep_q <= keep_d;
      last_q <= last_d;
    end
  end

endmodule

// File: rtl/conv_enc_punct.sv
// Parametrised convolutional encoder with inversion, puncturing and tail flush.
//
// state   | meaning
// --------+-------------------------------------------------------------
// ST_DATA | accepting data bits; in_last either starts the tail or ends frame
// ST_TAIL | feeding K-1 internal zero bits, no input accepted
module conv_enc_punct
  import conv_pkg::*;
#(
  parameter int                   K         = 7,
  parameter int                   R         = 2,
  parameter logic [R-1:0][K-1:0]  G         = {G_133, G_171},
  parameter logic [R-1:0]         INV       = GAL_INV,
  parameter int                   PUNCT_LEN = 1,
  parameter logic [PUNCT_LEN*R-1:0] PUNCT   = '1,
  parameter bit                   TAIL_EN   = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic in_valid,
  output logic in_ready,
  input  logic in_bit,
  input  logic in_last,
  output logic out_valid,
  input  logic out_ready,
  output logic out_bit,
  output logic out_last
);

  localparam int TW = $clog2(K);
  localparam int PW = (PUNCT_LEN > 1) ? $clog2(PUNCT_LEN) : 1;
  localparam int RW = $clog2(R + 1);

  // Parameter sanity, caught at elaboration rather than as a silent dead code.
  if (K < 3 || K > MAX_K) begin : g_bad_k
    $error("conv_enc_punct: K must be within 3..9");
  end
  if (R < 2 || R > MAX_R) begin : g_bad_r
    $error("conv_enc_punct: R must be within 2..4");
  end
  if (PUNCT_LEN < 1 || PUNCT_LEN > 8) begin : g_bad_plen
    $error("conv_enc_punct: PUNCT_LEN must be within 1..8");
  end
  for (genvar gp = 0; gp < PUNCT_LEN; gp++) begin : g_punct_chk
    if (PUNCT[gp*R +: R] == '0) begin : g_empty_col
      $error("conv_enc_punct: a puncture column keeps no coded bit");
    end
  end

  conv_state_t   state_q, state_d;
  logic [K-1:0]  sr_q, sr_d;
  logic [PW-1:0] p_q, p_d;
  logic [TW-1:0] tail_cnt_q, tail_cnt_d;

  logic          ser_empty;
  logic          ser_valid;
  logic [RW-1:0] ser_remaining;

  logic             can_load;
  logic             data_load;
  logic             tail_load;
  logic             sym_load;
  logic             tail_done;
  logic             frame_end;
  logic [K-1:0]     sr_shift;
  logic [MAX_K-1:0] sr_ext;
  logic [MAX_K-1:0] poly_ext;
  logic [R-1:0]     sym_bits;
  logic [R-1:0]     sym_keep;

  // Next-state, symbol generation and input handshake.
  always_comb begin
    // A symbol may load when the serializer is empty or its final bit leaves now;
    // this keeps out_ready -> in_ready combinational for full throughput.
    can_load  = ser_empty | (ser_valid & out_ready & (ser_remaining == RW'(1)));
    in_ready  = (state_q == ST_DATA) & can_load;
    data_load = in_valid & in_ready;
    tail_load = (state_q == ST_TAIL) & can_load;
    sym_load  = data_load | tail_load;

    // Coded bits come from the updated register so the new bit contributes.
    sr_shift = {data_load & in_bit, sr_q[K-1:1]};
    sr_ext   = '0;
    sr_ext[K-1:0] = sr_shift;
    poly_ext = '0;
    sym_bits = '0;
    for (int j = 0; j < R; j++) begin
      poly_ext = '0;
      poly_ext[K-1:0] = G[j];
      sym_bits[j] = conv_parity(poly_ext, sr_ext) ^ INV[j];
    end

    sym_keep = PUNCT[R-1:0];
    for (int p = 0; p < PUNCT_LEN; p++) begin
      if (p_q == PW'(p)) begin
        sym_keep = PUNCT[p*R +: R];
      end
    end

    tail_done = tail_load & (tail_cnt_q == TW'(1));
    frame_end = tail_done | (data_load & in_last & !TAIL_EN);

    state_d    = state_q;
    sr_d       = sr_q;
    p_d        = p_q;
    tail_cnt_d = tail_cnt_q;

    if (sym_load) begin
      if (frame_end) begin
        // sr[0] still holds the final data bit, so the register must be wiped.
        sr_d    = '0;
        p_d     = '0;
        state_d = ST_DATA;
      end else begin
        sr_d = sr_shift;
        p_d  = (p_q == PW'(PUNCT_LEN - 1)) ? '0 : p_q + PW'(1);
      end
      if (data_load && in_last && TAIL_EN) begin
        state_d    = ST_TAIL;
        tail_cnt_d = TW'(K - 1);
      end
      if (tail_load) begin
        tail_cnt_d = tail_cnt_q - TW'(1);
      end
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_DATA;
    end else begin
      state_q <= state_d;
    end
  end

  // Encoder shift register, puncture index and tail down-counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr_q       <= '0;
      p_q        <= '0;
      tail_cnt_q <= '0;
    end else begin
      sr_q       <= sr_d;
      p_q        <= p_d;
      tail_cnt_q <= tail_cnt_d;
    end
  end

  conv_serializer #(
    .R  (R),
    .RW (RW)
  ) u_ser (
    .clk         (clk),
    .rst_n       (rst_n),
    .load_i      (sym_load),
    .bits_i      (sym_bits),
    .keep_i      (sym_keep),
    .last_i      (frame_end),
    .out_valid_o (ser_valid),
    .out_ready_i (out_ready),
    .out_bit_o   (out_bit),
    .out_last_o  (out_last),
    .empty_o     (ser_empty),
    .remaining_o (ser_remaining)
  );

  assign out_valid = ser_valid;

endmodule
